// File: rtl/audio_frame_sequencer.sv
// Per-sample sequencer between the codec FIFO handshake and a multi-cycle
// effect chain (start/done), with FX timeout, output drop and statistics.
//
// Ports:
//   CLOCK_50, RESET_N            clock, async active-low reset
//   bypass                       skip effect chain for this frame
//   audio_in_available/L/R       codec input frame
//   read_audio_in                one-cycle input acknowledge
//   audio_out_allowed            codec can accept a frame
//   write_audio_out/L/R          one-cycle write strobe, held output frame
//   fx_start, fx_in_L/R          effect launch pulse and captured frame
//   fx_done, fx_out_L/R          effect result handshake
//   busy                         sequencer not idle
//   timeout_count, drop_count    saturating statistics
module audio_frame_sequencer #(
  parameter int DATA_W      = 32,
  parameter int FX_TIMEOUT  = 1000,
  parameter int OUT_TIMEOUT = 2048,
  parameter int CNT_W       = 16
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              bypass,
  input  logic              audio_in_available,
  input  logic              audio_out_allowed,
  input  logic [DATA_W-1:0] audio_in_L,
  input  logic [DATA_W-1:0] audio_in_R,
  output logic              read_audio_in,
  output logic              write_audio_out,
  output logic [DATA_W-1:0] audio_out_L,
  output logic [DATA_W-1:0] audio_out_R,
  output logic              fx_start,
  output logic [DATA_W-1:0] fx_in_L,
  output logic [DATA_W-1:0] fx_in_R,
  input  logic              fx_done,
  input  logic [DATA_W-1:0] fx_out_L,
  input  logic [DATA_W-1:0] fx_out_R,
  output logic              busy,
  output logic [CNT_W-1:0]  timeout_count,
  output logic [CNT_W-1:0]  drop_count
);

  localparam int TMAX =
    (FX_TIMEOUT > OUT_TIMEOUT) ? FX_TIMEOUT : OUT_TIMEOUT;
  localparam int TW = $clog2(TMAX + 1);

  localparam logic [TW-1:0] FX_LAST  = TW'(FX_TIMEOUT - 1);
  localparam logic [TW-1:0] OUT_LAST = TW'(OUT_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PROC,
    S_OUT
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [DATA_W-1:0] dry_l_q, dry_l_d;
  logic [DATA_W-1:0] dry_r_q, dry_r_d;
  logic [DATA_W-1:0] res_l_q, res_l_d;
  logic [DATA_W-1:0] res_r_q, res_r_d;
  logic [DATA_W-1:0] out_l_q, out_l_d;
  logic [DATA_W-1:0] out_r_q, out_r_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  tmo_q, tmo_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dry_l_d = dry_l_q;
    dry_r_d = dry_r_q;
    res_l_d = res_l_q;
    res_r_d = res_r_q;
    out_l_d = out_l_q;
    out_r_d = out_r_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    start_d = 1'b0;
    tmo_d   = tmo_q;
    drop_d  = drop_q;

    unique case (state_q)
      S_IDLE: begin
        if (audio_in_available) begin
          dry_l_d = audio_in_L;
          dry_r_d = audio_in_R;
          rd_d    = 1'b1;
          timer_d = '0;
          if (bypass) begin
            res_l_d = audio_in_L;
            res_r_d = audio_in_R;
            state_d = S_OUT;
          end else begin
            start_d = 1'b1;
            state_d = S_PROC;
          end
        end
      end
      S_PROC: begin
        // done has priority over a coinciding timeout
        if (fx_done) begin
          res_l_d = fx_out_L;
          res_r_d = fx_out_R;
          timer_d = '0;
          state_d = S_OUT;
        end else if (timer_q == FX_LAST) begin
          res_l_d = dry_l_q;
          res_r_d = dry_r_q;
          if (!(&tmo_q)) tmo_d = tmo_q + CNT_W'(1);
          timer_d = '0;
          state_d = S_OUT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_OUT: begin
        if (audio_out_allowed) begin
          out_l_d = res_l_q;
          out_r_d = res_r_q;
          wr_d    = 1'b1;
          state_d = S_IDLE;
        end else if (timer_q == OUT_LAST) begin
          if (!(&drop_q)) drop_d = drop_q + CNT_W'(1);
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      dry_l_q <= '0;
      dry_r_q <= '0;
      res_l_q <= '0;
      res_r_q <= '0;
      out_l_q <= '0;
      out_r_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      tmo_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      dry_l_q <= dry_l_d;
      dry_r_q <= dry_r_d;
      res_l_q <= res_l_d;
      res_r_q <= res_r_d;
      out_l_q <= out_l_d;
      out_r_q <= out_r_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
      drop_q  <= drop_d;
    end
  end

  // the dry copy doubles as the frame presented to the effect chain
  assign fx_in_L         = dry_l_q;
  assign fx_in_R         = dry_r_q;
  assign read_audio_in   = rd_q;
  assign write_audio_out = wr_q;
  assign fx_start        = start_q;
  assign audio_out_L     = out_l_q;
  assign audio_out_R     = out_r_q;
  assign busy            = busy_q;
  assign timeout_count   = tmo_q;
  assign drop_count      = drop_q;

endmodule

// File: tb/tb_audio_frame_sequencer.sv
// Scoreboard bench for audio_frame_sequencer: codec/effect model drives
// frames, expected pulses and frames are queued and checked by a monitor.
module tb_audio_frame_sequencer;

  localparam int FXT   = 8;
  localparam int OUTT  = 4;
  localparam int CW    = 2;
  localparam int NEVER = 99;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bypass = 1'b0;
  logic        avail = 1'b0;
  logic        allowed = 1'b0;
  logic [31:0] in_l = '0, in_r = '0;
  logic        rd, wr, start, busy, fx_done = 1'b0;
  logic [31:0] out_l, out_r, fxi_l, fxi_r;
  logic [31:0] fxo_l = '0, fxo_r = '0;
  logic [CW-1:0] tmo_cnt, drop_cnt;

  audio_frame_sequencer #(
    .DATA_W(32), .FX_TIMEOUT(FXT), .OUT_TIMEOUT(OUTT), .CNT_W(CW)
  ) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .bypass(bypass),
    .audio_in_available(avail), .audio_out_allowed(allowed),
    .audio_in_L(in_l), .audio_in_R(in_r),
    .read_audio_in(rd), .write_audio_out(wr),
    .audio_out_L(out_l), .audio_out_R(out_r),
    .fx_start(start), .fx_in_L(fxi_l), .fx_in_R(fxi_r),
    .fx_done(fx_done), .fx_out_L(fxo_l), .fx_out_R(fxo_r),
    .busy(busy), .timeout_count(tmo_cnt), .drop_count(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    int          cyc;
  } wexp_t;

  wexp_t wq[$];
  int    rq[$];
  int    sq[$];
  int    cyc = 0;
  int    n_chk = 0;
  int    n_fail = 0;
  int    tmo_exp = 0;
  int    drop_exp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // monitor: pops expectations whenever the DUT pulses
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr) begin
        if (wq.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          wexp_t e;
          e = wq.pop_front();
          chk("write_L", out_l, e.l);
          chk("write_R", out_r, e.r);
          chk("write_cycle", cyc, e.cyc);
        end
      end
      if (rd) begin
        if (rq.size() == 0) chk("unexpected_read", 1, 0);
        else chk("read_cycle", cyc, rq.pop_front());
      end
      if (start) begin
        if (sq.size() == 0) chk("unexpected_fx_start", 1, 0);
        else chk("fx_start_cycle", cyc, sq.pop_front());
      end
    end
  end

  function automatic int sat(input int v);
    return (v >= (1 << CW) - 1) ? (1 << CW) - 1 : v + 1;
  endfunction

  // d: PROC cycle index of fx_done (NEVER = none)
  // a: OUT cycles before allowed rises (>= OUTT = never)
  task automatic frame(input bit byp, input logic [31:0] dl, dr,
                       input logic [31:0] fl, fr,
                       input int d, input int a);
    int os, endr, last, c;
    logic [31:0] el, er;
    bit fx_ok;
    @(posedge clk); #1;
    bypass = byp; avail = 1'b1; in_l = dl; in_r = dr;
    fxo_l = fl; fxo_r = fr; allowed = 1'b0; fx_done = 1'b0;
    @(posedge clk); #1;
    c = cyc;
    avail = 1'b0;
    bypass = ~byp;
    fx_ok = !byp && d <= FXT - 1;
    if (byp) os = 1;
    else if (fx_ok) os = d + 2;
    else os = FXT + 1;
    el = fx_ok ? fl : dl;
    er = fx_ok ? fr : dr;
    if (!byp && !fx_ok) tmo_exp = sat(tmo_exp);
    rq.push_back(c);
    if (!byp) sq.push_back(c);
    if (a < OUTT) begin
      wq.push_back('{el, er, c + os + a});
      endr = os + a + 1;
    end else begin
      drop_exp = sat(drop_exp);
      endr = os + OUTT;
    end
    last = endr;
    if (d != NEVER && d + 1 > last) last = d + 1;
    for (int r = 1; r <= last; r++) begin
      fx_done = (d != NEVER) && (r == d + 1);
      allowed = (a < OUTT) && (r >= os + a);
      if (r == 1) begin
        chk("fx_in_L", fxi_l, dl);
        chk("fx_in_R", fxi_r, dr);
        chk("busy_frame", busy, 1);
      end
      @(posedge clk); #1;
    end
    fx_done = 1'b0;
    allowed = 1'b0;
    chk("busy_idle", busy, 0);
    chk("timeout_count", tmo_cnt, tmo_exp);
    chk("drop_count", drop_cnt, drop_exp);
  endtask

  task automatic reset_mid();
    int c;
    @(posedge clk); #1;
    bypass = 1'b0; avail = 1'b1;
    in_l = 32'hAAAA_0001; in_r = 32'h5555_0002;
    @(posedge clk); #1;
    c = cyc;
    avail = 1'b0;
    rq.push_back(c);
    sq.push_back(c);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_read", rd, 0);
    chk("rst_write", wr, 0);
    chk("rst_start", start, 0);
    chk("rst_out_L", out_l, 0);
    chk("rst_out_R", out_r, 0);
    chk("rst_fx_in_L", fxi_l, 0);
    chk("rst_tmo", tmo_cnt, 0);
    chk("rst_drop", drop_cnt, 0);
    tmo_exp = 0;
    drop_exp = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1 chk("post_rst_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("reset_busy", busy, 0);
    chk("reset_out_L", out_l, 0);
    chk("reset_fx_in_L", fxi_l, 0);
    chk("reset_tmo", tmo_cnt, 0);
    chk("reset_drop", drop_cnt, 0);
    chk("reset_pulses", {rd, wr, start}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    frame(1, 32'h0000_1234, 32'hFFFF_0000, 32'hDEAD_BEEF, 32'h0, NEVER, 0);
    frame(0, 32'h100, 32'h101, 32'h200, 32'h201, 5, 0);
    frame(0, 32'h300, 32'h301, 32'h400, 32'h401, FXT + 1, 3);
    frame(0, 32'h500, 32'h501, 32'h600, 32'h601, FXT - 1, 1);
    frame(0, 32'h700, 32'h701, 32'h800, 32'h801, 0, 0);
    frame(1, 32'h900, 32'h901, 32'hA00, 32'hA01, 0, OUTT);
    frame(1, 32'hB00, 32'hB01, 32'hC00, 32'hC01, NEVER, 0);
    reset_mid();
    frame(0, 32'hD00, 32'hD01, 32'hE00, 32'hE01, 2, 0);
    for (int i = 0; i < 5; i++)
      frame(0, $urandom, $urandom, $urandom, $urandom, NEVER, 0);
    for (int i = 0; i < 40; i++) begin
      bit byp;
      int d, a;
      byp = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 5) == 0) ? NEVER : $urandom_range(0, 10);
      a = ($urandom_range(0, 4) == 0) ? OUTT : $urandom_range(0, 3);
      frame(byp, $urandom, $urandom, $urandom, $urandom, d, a);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("writes_pending", wq.size(), 0);
    chk("reads_pending", rq.size(), 0);
    chk("starts_pending", sq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_frame_sequencer.md
Name: audio_frame_sequencer

Overview:
- Per-sample controller between the audio codec handshake (available/allowed, read/write pulses) and a multi-cycle effect chain using a start/done handshake.
- Captures one stereo frame and launches the chain. Waits for the result, or substitutes the dry sample on timeout. Then writes the frame to the codec.
- Replaces the free-running single-cycle audio tick, so effects may take many CLOCK_50 cycles per sample. Exposes timeout and drop statistics to the top level.

Parameters:
- DATA_W, 32: sample width per channel, signed.
- FX_TIMEOUT, 1000: maximum cycles spent in PROC waiting for fx_done (must be ≥ 1).
- OUT_TIMEOUT, 2048: maximum cycles spent in OUT waiting for audio_out_allowed (must be ≥ 1).
- CNT_W, 16: width of the statistics counters.

Ports:
- CLOCK_50, input, 1: single system clock, rising edge.
- RESET_N, input, 1: reset, asynchronous and active-low.
- bypass, input, 1: 1 = skip the effect chain and pass the dry frame through.
- audio_in_available, input, 1: codec has an input frame.
- audio_out_allowed, input, 1: codec can accept an output frame.
- audio_in_L / audio_in_R, input, DATA_W each: codec input samples.
- read_audio_in, output, 1: one-cycle acknowledge of the captured input frame.
- write_audio_out, output, 1: one-cycle write strobe for the output frame.
- audio_out_L / audio_out_R, output, DATA_W each: output frame, registered and held between writes.
- fx_start, output, 1: one-cycle launch pulse to the effect chain.
- fx_in_L / fx_in_R, output, DATA_W each: captured frame, held stable from fx_start until the next capture.
- fx_done, input, 1: effect chain result valid; sampled only in PROC.
- fx_out_L / fx_out_R, input, DATA_W each: effect chain result, valid when fx_done=1.
- busy, output, 1: state != IDLE (registered).
- timeout_count, output, CNT_W: number of FX timeouts, saturating.
- drop_count, output, CNT_W: number of dropped output frames, saturating.

Behaviour:
- Reset (RESET_N=0, asynchronous): state=IDLE.
  - All outputs 0: pulses, audio_out_*, fx_in_*, busy, both counters.
  - Internal timer and result registers cleared.
  - Reset asserted mid-frame aborts the frame: no read/write/start pulse afterwards, counters cleared.
- All outputs are registered. Every pulse output is high for exactly one cycle per event.
- States: IDLE, PROC, OUT.
- IDLE, at an edge with audio_in_available=1:
  - Capture audio_in_L/R into fx_in_L/R and into the dry register.
  - Drive read_audio_in=1 in the next cycle.
  - If bypass=0: drive fx_start=1 in the next cycle, go to PROC with timer=0.
  - If bypass=1: result = dry, no fx_start, go to OUT.
  - bypass is sampled only at this capture edge; changes mid-frame do not affect the current frame.
- PROC, at each edge:
  - If fx_done=1: result = fx_out_L/R, go to OUT. fx_done in the first PROC cycle (same cycle as fx_start) is accepted.
  - Otherwise, if timer == FX_TIMEOUT-1: result = dry, timeout_count += 1 (saturating), go to OUT.
  - Otherwise timer += 1.
  - If fx_done and the timeout coincide, fx_done wins and timeout_count is unchanged.
  - PROC lasts at most FX_TIMEOUT cycles.
- fx_done outside PROC is ignored; a late done after a timeout is discarded.
- OUT, timer=0 on entry, at each edge:
  - If audio_out_allowed=1: audio_out_L/R = result, write_audio_out=1 in the next cycle, go to IDLE.
  - Otherwise, if timer == OUT_TIMEOUT-1: drop the frame (no write, audio_out_* unchanged), drop_count += 1 (saturating), go to IDLE.
  - Otherwise timer += 1.
- audio_in_available while busy is not acknowledged. The codec holds it until the sequencer returns to IDLE.
- Minimum frame latency, bypass with allowed held high:
  - capture edge k: read pulse in cycle k+1;
  - write edge k+1: write pulse in cycle k+2.
- Minimum frame latency, effect path with done at the first PROC cycle:
  - read and fx_start in cycle k+1;
  - write pulse in cycle k+3.
- Counters hold at 2^CNT_W-1 (saturate) and never wrap.
- Data is passed unmodified; there is no arithmetic on samples.

Test Plan:
- Reset then bypass=1, allowed=1, available pulsed with L=0x00001234, R=0xFFFF0000 → read in cycle k+1; write in cycle k+2 with audio_out equal to the inputs; fx_start never asserts.
- bypass=0, input L=0x100; model returns fx_out_L=0x200 with done 5 cycles after fx_start → exactly one fx_start; write_audio_out follows; audio_out_L=0x200; timeout_count=0.
- bypass=0, FX_TIMEOUT=8, fx_done never asserted → after 8 PROC cycles audio_out = dry sample and timeout_count=1. A done pulse 2 cycles later is ignored, with no extra write.
- fx_done asserted on the exact cycle timer=FX_TIMEOUT-1 → audio_out = fx_out; timeout_count unchanged.
- audio_out_allowed held 0 with OUT_TIMEOUT=4 → no write; drop_count=1; back in IDLE (busy=0). A following frame with allowed=1 is written normally.
- RESET_N pulsed low during PROC → all outputs 0 immediately (asynchronous); no write pulse occurs; after release the next frame is processed normally.
- CNT_W=2 with 5 forced timeouts → timeout_count saturates at 3.
